// File: rtl/pong_pkg.sv
// Shared Pong constants: match state encoding, screen geometry and miss bounds.
// Imported by the match sequencer and its ball miss detector.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BALL_SIZE     = 8;
  localparam int TOP_MARGIN    = 32;

  // Distance from each side wall that counts as a miss.
  localparam logic [9:0] MISS_MARGIN = 10'd8;
  // Positions at or above this are a ball that wrapped below zero.
  localparam logic [9:0] WRAP_BOUND  = 10'd1016;

  // Score increment that sticks at 15.
  function automatic logic [3:0] sat_inc(input logic [3:0] s,
                                         input logic inc);
    if (inc && s != 4'd15) sat_inc = s + 4'd1;
    else                   sat_inc = s;
  endfunction

endpackage

// File: rtl/ball_miss_detect.sv
// Classifies one ball's x position as a left miss, a right miss or in play.
// Purely combinational; a disabled ball never reports a miss.
module ball_miss_detect #(
  parameter int SCREEN_W = 640,
  parameter int BALL_W   = 8
) (
  input  logic [9:0] ball_x,
  input  logic       enable,
  output logic       miss_left,
  output logic       miss_right
);
  import pong_pkg::*;

  localparam logic [10:0] RIGHT_EDGE =
    11'(SCREEN_W) - {1'b0, MISS_MARGIN};

  logic [10:0] far_x;
  logic        at_left;

  assign far_x   = {1'b0, ball_x} + 11'(BALL_W);
  assign at_left = (ball_x < MISS_MARGIN) || (ball_x >= WRAP_BOUND);

  assign miss_left  = enable && at_left;
  assign miss_right = enable && !at_left && (far_x > RIGHT_EDGE);

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: IDLE/SERVE/PLAY/OVER flow, scoring and winner.
// Gates the frame strobe into the ball block and pulses ball re-centre.
module match_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_DELAY  = 60,
  parameter int SCREEN_WIDTH = 640,
  parameter int BALL_SIZE    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [1:0] game_mode_sel,
  input  logic [9:0] ball_x_0,
  input  logic [9:0] ball_x_1,
  output logic [1:0] main_state,
  output logic [1:0] game_mode,
  output logic       paused,
  output logic       run_tick,
  output logic       ball_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);
  import pong_pkg::*;

  localparam logic [7:0] LAST_CNT = 8'(SERVE_DELAY - 1);
  localparam logic [3:0] WIN      = 4'(WIN_SCORE);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] mode_n;
  logic       paused_n;
  logic       br_n;
  logic [3:0] s1_n, s2_n;
  logic [1:0] win_n;

  logic       ml0, mr0, ml1, mr1;
  logic       hit_l, hit_r;
  logic [3:0] s1_up, s2_up;
  logic       reach1, reach2;

  ball_miss_detect #(
    .SCREEN_W (SCREEN_WIDTH),
    .BALL_W   (BALL_SIZE)
  ) u_miss0 (
    .ball_x     (ball_x_0),
    .enable     (1'b1),
    .miss_left  (ml0),
    .miss_right (mr0)
  );

  ball_miss_detect #(
    .SCREEN_W (SCREEN_WIDTH),
    .BALL_W   (BALL_SIZE)
  ) u_miss1 (
    .ball_x     (ball_x_1),
    .enable     (game_mode == 2'd1),
    .miss_left  (ml1),
    .miss_right (mr1)
  );

  assign hit_l  = ml0 | ml1;
  assign hit_r  = mr0 | mr1;
  assign s1_up  = sat_inc(score1, hit_r);
  assign s2_up  = sat_inc(score2, hit_l);
  assign reach1 = s1_up >= WIN;
  assign reach2 = s2_up >= WIN;

  assign main_state = state;
  assign run_tick   = refresh_tick && (state == S_PLAY) && !paused;

  // Match state and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      game_mode  <= 2'd0;
      paused     <= 1'b0;
      ball_reset <= 1'b0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      winner     <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      game_mode  <= mode_n;
      paused     <= paused_n;
      ball_reset <= br_n;
      score1     <= s1_n;
      score2     <= s2_n;
      winner     <= win_n;
    end
  end

  // Next-state, serve count, scoring and winner decisions.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mode_n   = game_mode;
    paused_n = paused;
    br_n     = 1'b0;
    s1_n     = score1;
    s2_n     = score2;
    win_n    = winner;
    unique case (state)
      S_IDLE: begin
        if (start_btn) begin
          mode_n  = {1'b0, game_mode_sel == 2'd1};
          s1_n    = 4'd0;
          s2_n    = 4'd0;
          win_n   = 2'd0;
          cnt_n   = 8'd0;
          state_n = S_SERVE;
          br_n    = 1'b1;
        end
      end
      S_SERVE: begin
        if (refresh_tick) begin
          if (cnt == LAST_CNT) begin
            cnt_n   = 8'd0;
            state_n = S_PLAY;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_PLAY: begin
        paused_n = paused ^ pause_btn;
        if (refresh_tick && !paused && (hit_l || hit_r)) begin
          s1_n     = s1_up;
          s2_n     = s2_up;
          paused_n = 1'b0;
          if (reach1 || reach2) begin
            win_n   = {reach2, reach1};
            state_n = S_OVER;
          end else begin
            state_n = S_SERVE;
            br_n    = 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start_btn) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the Pong datapath: owns the IDLE/SERVE/PLAY/OVER flow, detects when a ball leaves the playfield, keeps both players' scores and declares a winner. It drives `main_state` and `game_mode` into the ball block, gates its `refresh_tick` through `run_tick`, and re-centres the balls between points with a one-cycle `ball_reset` pulse. It sits between the button debouncers and the ball/paddle/render blocks.

## Interface
- `WIN_SCORE`, 5: points needed to win, 1..15.
- `SERVE_DELAY`, 60: refresh ticks spent in SERVE before play resumes, 1..255.
- `SCREEN_WIDTH`, 640: playfield width in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `refresh_tick` in 1: one-cycle frame strobe.
- `start_btn` in 1: debounced one-cycle start pulse.
- `pause_btn` in 1: debounced one-cycle pause-toggle pulse.
- `game_mode_sel` in 2: requested mode; 1 = two balls, any other value = one ball.
- `ball_x_0`, `ball_x_1` in 10: current ball x positions from the ball block.
- `main_state` out 2: 0 IDLE, 1 SERVE, 2 PLAY (including paused), 3 OVER.
- `game_mode` out 2: latched mode, 0 or 1 only.
- `paused` out 1: high while play is paused.
- `run_tick` out 1: `refresh_tick` forwarded only in unpaused PLAY.
- `ball_reset` out 1: registered one-cycle re-centre pulse to the ball block.
- `score1`, `score2` out 4: left and right player scores.
- `winner` out 2: 0 none, 1 left, 2 right, 3 draw.

## Operation
- **Reset values.** `main_state`=IDLE, `game_mode`=0, `paused`=0, `ball_reset`=0, scores=0, `winner`=0, serve counter=0. `run_tick`=0 because the state is not PLAY. A reset asserted mid-match aborts immediately to these values.
- **IDLE.** On `start_btn`:
  - latch `game_mode` (1 if `game_mode_sel`==1, else 0);
  - clear scores and `winner`;
  - go to SERVE with `ball_reset` asserted.
- **SERVE.** Counts `refresh_tick`s. After the `SERVE_DELAY`-th tick, move to PLAY and clear the counter. `start_btn` and `pause_btn` are ignored.
- **PLAY.**
  - `pause_btn` toggles `paused`.
  - While paused, `run_tick`=0 and miss detection is disabled.
  - On each unpaused `refresh_tick`, classify each active ball (ball 1 only when `game_mode`==1):
    - left miss: `ball_x` < 8 or `ball_x` >= 1016. The 1016 bound catches wrap-around below 0.
    - right miss: 8 <= `ball_x` < 1016 and `ball_x` + `BALL_SIZE` > `SCREEN_WIDTH` − 8, computed at 11 bits.
  - Scoring:
    - a left miss from any ball gives `score2` +1;
    - a right miss from any ball gives `score1` +1;
    - each side gains at most 1 point per tick; both sides may score on the same tick;
    - scores saturate at 15.
  - Any miss ends the point:
    - if either updated score reaches `WIN_SCORE`, go to OVER. `winner` = 1 or 2, or 3 if both sides reach it on the same tick;
    - otherwise go to SERVE with `ball_reset` asserted.
- **OVER.** Scores and `winner` hold. On `start_btn`, go to IDLE; scores stay visible until the next start.
- `paused` is cleared on every exit from PLAY.

## Timing
- `run_tick` = `refresh_tick` AND registered (state==PLAY AND !`paused`). It is zero-latency and combinational from `refresh_tick` only.
- Miss detection samples `ball_x` in the cycle `refresh_tick` is high. That is pre-move, because the ball updates on the same edge.
- Scores, state and `ball_reset` update on that same edge. `ball_reset` is high for exactly the first clock cycle of SERVE and low in all other cycles.
- Serve to play: PLAY is entered on the edge that samples the `SERVE_DELAY`-th tick. That tick itself is not forwarded; the first `run_tick` occurs on the next `refresh_tick`.
- `start_btn` or `pause_btn` coinciding with `refresh_tick`:
  - the button is processed on the same edge;
  - a pause entered on a miss tick still scores that miss, because the miss is evaluated against the pre-edge `paused`.
- Buttons held for more than one cycle are the debouncer's responsibility. Each high cycle counts as one pulse.

## Structure
- `pong_pkg` holds:
  - the state encoding for `main_state`;
  - `SCREEN_WIDTH`, `SCREEN_HEIGHT`, `BALL_SIZE`, `TOP_MARGIN`;
  - the miss margin (8) and wrap bound (1016).
- Sub-module `ball_miss_detect`: combinational, inputs `ball_x` and `enable`, outputs `miss_left` and `miss_right`. It is instantiated twice, with ball 1's `enable` tied to `game_mode`==1.
- The FSM, serve counter, scoring and winner logic live in `match_ctrl`.

## Test plan
- **Start and serve.** Reset, then `start_btn` with `game_mode_sel`=1 → `game_mode`=1, `main_state`=1, `ball_reset` high exactly 1 cycle; after 60 `refresh_tick`s `main_state`=2; first `run_tick` on tick 61.
- **Single miss and wrap.** In PLAY, `ball_x_0`=1020 on a tick → `score2`=1, SERVE, `ball_reset` pulse. Then `ball_x_0`=633 → `score1`=1.
- **Simultaneous misses.** Mode 1, `ball_x_0`=2 and `ball_x_1`=3 on one tick → only `score2` +1. Then `ball_x_0`=2 and `ball_x_1`=630 → both scores +1.
- **Win and draw.** Scores 4–3, left miss → `score2`=4, SERVE. Scores 4–4, both sides miss on one tick → OVER with `winner`=3. `start_btn` → IDLE.
- **Pause.** `pause_btn` in PLAY → `run_tick` stays 0 and `ball_x_0`=0 does not score. A second `pause_btn` resumes play. `pause_btn` in SERVE → no effect.
- **Reset mid-operation.** Assert `reset` mid-SERVE with scores 2–1 → all outputs return to reset values asynchronously, before the next clock edge.
